// File: rtl/grid_controller.sv
// Cursor/write sequencer for the 4x4 colour grid: edge-detects buttons, scans the
// target row and column for a duplicate colour, and publishes the board once per frame.
module grid_controller #(
  parameter int ERR_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btnU,
  input  logic        btnD,
  input  logic        btnL,
  input  logic        btnR,
  input  logic        btnC,
  input  logic [11:0] sw,
  input  logic        frameTick,
  output logic [3:0]  row,
  output logic [3:0]  col,
  output logic [47:0] x1,
  output logic [47:0] x2,
  output logic [47:0] x3,
  output logic [47:0] x4,
  output logic        error,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, REJECT} state_t;

  localparam logic [7:0] ERR_LOAD = 8'(ERR_FRAMES);

  // Press vector order is also the arbitration priority: C, U, D, L, R.
  localparam int P_C = 4;
  localparam int P_U = 3;
  localparam int P_D = 2;
  localparam int P_L = 1;
  localparam int P_R = 0;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

  state_t            state, state_nx;
  logic [4:0]        lvl, prev, press;
  logic [1:0]        r, c, r_nx, c_nx;
  logic [2:0]        k, k_nx;
  logic              hit, hit_nx;
  logic [11:0]       color, color_nx;
  logic [7:0]        cnt, cnt_nx;
  logic              wr_en, reload;
  logic [15:0][11:0] wbuf;
  logic [3:0]        scan_idx;
  logic              scan_skip;
  logic              scan_eq;

  assign lvl   = {btnC, btnU, btnD, btnL, btnR};
  assign press = lvl & ~prev;

  // k = 0..3 walks the cursor row, k = 4..7 walks the cursor column; the
  // target cell itself is skipped in both passes.
  always_comb begin
    scan_idx  = {r, k[1:0]};
    scan_skip = (k[1:0] == c);
    if (k[2]) begin
      scan_idx  = {k[1:0], c};
      scan_skip = (k[1:0] == r);
    end
    scan_eq = !scan_skip && (wbuf[scan_idx] == color);
  end

  always_comb begin
    state_nx = state;
    r_nx     = r;
    c_nx     = c;
    k_nx     = k;
    hit_nx   = hit;
    color_nx = color;
    wr_en    = 1'b0;
    reload   = 1'b0;
    unique case (state)
      IDLE: begin
        if (press[P_C]) begin
          state_nx = SCAN;
          color_nx = sw;
          hit_nx   = 1'b0;
          k_nx     = 3'd0;
        end else if (press[P_U]) begin
          r_nx = r - 2'd1;
        end else if (press[P_D]) begin
          r_nx = r + 2'd1;
        end else if (press[P_L]) begin
          c_nx = c - 2'd1;
        end else if (press[P_R]) begin
          c_nx = c + 2'd1;
        end
      end
      SCAN: begin
        hit_nx = hit | scan_eq;
        k_nx   = k + 3'd1;
        if (k == 3'd7) begin
          // A zero colour clears the cell and never counts as a conflict.
          state_nx = (hit_nx && (color != 12'h000)) ? REJECT : COMMIT;
        end
      end
      COMMIT: begin
        wr_en    = 1'b1;
        state_nx = IDLE;
      end
      REJECT: begin
        reload   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A reload in the same cycle as a frame tick takes precedence over the decrement.
  always_comb begin
    cnt_nx = cnt;
    if (reload) begin
      cnt_nx = ERR_LOAD;
    end else if (frameTick && (cnt != 8'd0)) begin
      cnt_nx = cnt - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      prev  <= 5'b11111;
      r     <= 2'd0;
      c     <= 2'd0;
      k     <= 3'd0;
      hit   <= 1'b0;
      color <= 12'h000;
      cnt   <= 8'd0;
      row   <= 4'b0001;
      col   <= 4'b0001;
      busy  <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_nx;
      prev  <= lvl;
      r     <= r_nx;
      c     <= c_nx;
      k     <= k_nx;
      hit   <= hit_nx;
      color <= color_nx;
      cnt   <= cnt_nx;
      row   <= onehot4(r_nx);
      col   <= onehot4(c_nx);
      busy  <= (state_nx != IDLE);
      error <= (cnt_nx != 8'd0);
    end
  end

  // Display buses sample the pre-write board if a tick lands on COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      wbuf <= '0;
      x1   <= '0;
      x2   <= '0;
      x3   <= '0;
      x4   <= '0;
    end else begin
      if (wr_en) begin
        wbuf[{r, c}] <= color;
      end
      if (frameTick) begin
        x1 <= wbuf[3:0];
        x2 <= wbuf[7:4];
        x3 <= wbuf[11:8];
        x4 <= wbuf[15:12];
      end
    end
  end

endmodule

// File: tb/tb_grid_controller.sv
// Directed bench for grid_controller: reset, cursor wrap, write/publish, conflict
// reject, clear, and simultaneous-event cases with hand-computed expectations.
module tb_grid_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        btnU, btnD, btnL, btnR, btnC;
  logic [11:0] sw;
  logic        frameTick;
  logic [3:0]  row, col;
  logic [47:0] x1, x2, x3, x4;
  logic        error, busy;

  int errors = 0;
  int checks = 0;
  int n;

  grid_controller #(.ERR_FRAMES(2)) dut (
    .clk(clk), .reset(reset),
    .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR), .btnC(btnC),
    .sw(sw), .frameTick(frameTick),
    .row(row), .col(col),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // m = {C, U, D, L, R}; one-cycle press followed by one-cycle release.
  task automatic press(input logic [4:0] m);
    {btnC, btnU, btnD, btnL, btnR} = m;
    step();
    {btnC, btnU, btnD, btnL, btnR} = 5'b00000;
    step();
  endtask

  task automatic tick();
    frameTick = 1'b1;
    step();
    frameTick = 1'b0;
  endtask

  // Returns with the bench in the first IDLE cycle; busy_cycles counts busy-high cycles.
  task automatic write_cell(input logic [11:0] color, output int busy_cycles);
    sw   = color;
    btnC = 1'b1;
    step();
    btnC = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 20) begin
      busy_cycles++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    {btnC, btnU, btnD, btnL, btnR} = 5'b10000;
    sw = 12'h000;
    frameTick = 1'b0;
    repeat (3) step();
    check("rst_row", row, 4'b0001);
    check("rst_col", col, 4'b0001);
    check("rst_x", {x1, x2, x3, x4} == '0, 1'b1);
    check("rst_err", error, 1'b0);
    check("rst_busy", busy, 1'b0);

    reset = 1'b0;
    n = 0;
    repeat (12) begin
      step();
      if (busy) n++;
    end
    check("held_c_no_fire", n, 0);
    btnC = 1'b0;
    step();

    press(5'b00010);
    check("wrap_left", col, 4'b1000);
    press(5'b01000);
    check("wrap_up", row, 4'b1000);
    press(5'b00100);
    check("wrap_down", row, 4'b0001);
    press(5'b00001);
    check("wrap_right", col, 4'b0001);

    write_cell(12'hF00, n);
    check("w00_busy_len", n, 9);
    check("w00_x1_held", x1, 48'h0);
    check("w00_err", error, 1'b0);
    tick();
    check("w00_pub", x1[11:0], 12'hF00);

    press(5'b00010);
    check("to_03_col", col, 4'b1000);
    write_cell(12'hF00, n);
    check("rej03_busy_len", n, 9);
    check("rej03_err_rise", error, 1'b1);
    tick();
    check("rej03_cell", x1[47:36], 12'h000);
    check("rej03_keep00", x1[11:0], 12'hF00);
    check("rej03_err_tick1", error, 1'b1);
    tick();
    check("rej03_err_tick2", error, 1'b0);

    press(5'b00100);
    press(5'b00001);
    check("to_10_row", row, 4'b0010);
    check("to_10_col", col, 4'b0001);
    write_cell(12'h0F0, n);
    tick();
    check("w10_pub", x2[11:0], 12'h0F0);
    check("w10_err", error, 1'b0);

    press(5'b00100);
    press(5'b00100);
    check("to_30_row", row, 4'b1000);
    write_cell(12'h0F0, n);
    check("rej30_err", error, 1'b1);
    tick();
    check("rej30_cell", x4[11:0], 12'h000);
    tick();
    check("rej30_err_clear", error, 1'b0);

    press(5'b01000);
    press(5'b01000);
    check("back_10_row", row, 4'b0010);
    write_cell(12'h000, n);
    check("clr10_busy_len", n, 9);
    check("clr10_err", error, 1'b0);
    tick();
    check("clr10_pub", x2[11:0], 12'h000);

    sw = 12'h00F;
    {btnC, btnR} = 2'b11;
    step();
    {btnC, btnR} = 2'b00;
    check("cr_busy", busy, 1'b1);
    check("cr_col_held", col, 4'b0001);
    step();
    btnR = 1'b1;
    step();
    btnR = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      step();
    end
    check("scan_r_done", busy, 1'b0);
    check("scan_r_ignored", col, 4'b0001);
    tick();
    check("cr_pub", x2[11:0], 12'h00F);

    press(5'b00001);
    check("to_11_col", col, 4'b0010);
    write_cell(12'h00F, n);
    check("rej11_err", error, 1'b1);
    tick();
    check("rej11_err_cnt1", error, 1'b1);
    sw = 12'h00F;
    btnC = 1'b1;
    step();
    btnC = 1'b0;
    repeat (8) step();
    check("tickrej_busy_t9", busy, 1'b1);
    frameTick = 1'b1;
    step();
    frameTick = 1'b0;
    check("tickrej_err_t10", error, 1'b1);
    check("tickrej_idle_t10", busy, 1'b0);
    tick();
    check("tickrej_reloaded", error, 1'b1);
    check("rej11_cell", x2[23:12], 12'h000);
    tick();
    check("tickrej_err_fall", error, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
